pl_memwb_hs: RTL and testbench
==============================

Name: pl_memwb_hs

Overview:
Parametrised memory/write-back pipeline stage with a valid/ready handshake, multi-cycle data-memory loads and acknowledged IO reads with timeout.
- Sits between the EX pipeline register and the register file / data memory / IO ports.
- Stalls EX while a load or IO read is outstanding.
- Produces registered write-back data, destination and branch flags.

Parameters:
- NUM_DOMAINS, 1, number of RNS/binary domains in the result bus.
- DATA_WID, 8, width of one domain, of memory data and of IO data.
- REG_ADDR_WID, 3, register-file address width.
- DMEM_LAT, 1, data-memory read latency in cycles; legal range 0..7.
- IO_TIMEOUT, 16, maximum cycles to wait for io_read_ack; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- ex_valid  in  1  EX register holds an instruction.
- ex_ready  out  1  stage accepts this cycle; equals (state==IDLE).
- ex_ctrl  in  10  [0]store [1]reg_wr [2]save_cout [3]inv_ex [4]load [5]inv_fetch [6]inv_decode [7]dest_rns [8]outp [9]inp.
- ex_dest  in  REG_ADDR_WID  destination register.
- operation_result  in  NUM_DOMAINS*DATA_WID  ALU result; domain 1 in the MSBs.
- branch_conds_ex  in  5  [0:2] compare flags, [3] carry, [4] compare_true.
- dmem_dout  in  DATA_WID  memory read data.
- io_read_data  in  DATA_WID  input-port data.
- io_read_ack  in  1  input-port data valid.
- mem_wr_en  out  1  combinational store enable.
- dmem_rd_en  out  1  combinational load pulse.
- invalidate_instr  out  1  (inv_ex | inv_fetch | inv_decode) & ex_valid.
- io_read_strobe  out  1  held high while an IO read is pending.
- io_write_strobe  out  1  registered one-cycle pulse.
- io_write_data  out  DATA_WID  registered output-port data.
- io_timeout  out  1  one-cycle pulse on IO read abort.
- wb_valid  out  1  write-back registers valid this cycle.
- reg_wr_en  out  1  registered register-file write enable.
- wb_dest  out  REG_ADDR_WID  write-back destination.
- wr_data  out  NUM_DOMAINS*DATA_WID  write-back data.
- branch_conds_memwb  out  4  [0:2] compare flags, [3] carry.

Behaviour:
- Reset (async): state IDLE; all registered outputs, counters and the pending latch go to 0; any pending load or IO read is discarded and io_read_strobe drops immediately.
- Accept: ex_valid & ex_ready. The instruction is invalidated if invalidate_instr=1.
  - An invalidated instruction has no side effects: no store, no load, no IO, wb_valid=0, branch flags 0.
  - An accepted instruction's ctrl/dest/result are latched, so EX need not hold them stable.
- States: IDLE, MEM_WAIT, IO_WAIT.
- ALU op (no load, no inp): registered; wb_valid=1 and reg_wr_en=ctrl[1] in cycle T+1.
  - Store: mem_wr_en=1 in cycle T.
  - outp: io_write_strobe=1 and io_write_data=operation_result[DATA_WID-1:0] in cycle T+1.
- Load: dmem_rd_en=1 in cycle T.
  - DMEM_LAT=0: dmem_dout is sampled at end of T.
  - DMEM_LAT>0: go to MEM_WAIT with a counter loaded to DMEM_LAT-1. dmem_dout is sampled when the counter reaches 0, i.e. at end of cycle T+DMEM_LAT.
  - wb_valid follows one cycle later, then return to IDLE.
- inp: io_read_strobe=1 from cycle T until ack (combinational in T, registered in IO_WAIT).
  - Ack in T: complete as ALU latency.
  - Otherwise go to IO_WAIT. Capture io_read_data on the ack cycle; wb_valid next cycle.
  - After IO_TIMEOUT cycles without ack: io_timeout pulses, wb_valid=1, reg_wr_en=0, wr_data=0, return to IDLE.
- Load/IO data is zero-extended into the LSB domain; all other domains are 0.
- Branch flags are updated one cycle after accept of a valid instruction, otherwise cleared to 0 every cycle.
  - [3] is loaded only if save_cout=1.
  - [0:2] are loaded only if branch_conds_ex[4]=1.
- Precedence: inp > load > ALU; if both load and inp are set, inp wins and no dmem_rd_en is issued.
- ex_valid while ex_ready=0 is ignored.
- wb_valid, reg_wr_en and io_write_strobe are cleared every cycle in which nothing completes.

Optional Feature:
- PL_MEMWB_FWD_EN defined: adds outputs fwd_valid (1), fwd_dest (REG_ADDR_WID) and fwd_data (NUM_DOMAINS*DATA_WID).
  - These equal wb_valid&reg_wr_en, wb_dest and wr_data, for EX-stage bypassing.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package holds:
  - ex_ctrl bit-index constants (CTRL_STORE=0 ... CTRL_INP=9).
  - Branch-flag indices.
  - State encoding (IDLE=2'd0, MEM_WAIT=2'd1, IO_WAIT=2'd2).
- One sub-module, pl_memwb_wait_ctr: a loadable down-counter with a zero flag, instanced twice (DMEM_LAT wait and IO_TIMEOUT).

Test Plan:
- ALU op: result 8'h5A, reg_wr=1, dest 3 -> next cycle wb_valid=1, reg_wr_en=1, wb_dest=3, wr_data=8'h5A.
- Load, DMEM_LAT=2, dmem_dout=8'hC3 at T+2 -> ex_ready low in T+1..T+2; wb_valid in T+3; wr_data=8'hC3; with NUM_DOMAINS=2, wr_data=16'h00C3.
- inp with ack at T+4 carrying 8'h7E -> io_read_strobe high T..T+4; wr_data=8'h7E at T+5.
- inp with no ack, IO_TIMEOUT=4 -> io_timeout pulse, reg_wr_en=0, ready restored.
- Store with inv_fetch=1 -> mem_wr_en=0, wb_valid=0, branch_conds_memwb=0; compare_true=1, flags 3'b101 -> branch_conds_memwb[0:2]=101.
- Reset asserted mid-MEM_WAIT -> all outputs 0 immediately, state IDLE, ex_ready=1 after release.

Source files
------------

// File: rtl/pl_memwb_hs_pkg.sv
// Shared definitions for the MEM/WB handshake stage.
//   - ex_ctrl bit positions
//   - branch-flag bit positions (EX-side 5-bit and MEM/WB-side 4-bit buses)
//   - stage state encoding
//   - counter width helper
package pl_memwb_hs_pkg;

    localparam int CTRL_W         = 10;
    localparam int CTRL_STORE     = 0;
    localparam int CTRL_REG_WR    = 1;
    localparam int CTRL_SAVE_COUT = 2;
    localparam int CTRL_INV_EX    = 3;
    localparam int CTRL_LOAD      = 4;
    localparam int CTRL_INV_FETCH = 5;
    localparam int CTRL_INV_DEC   = 6;
    localparam int CTRL_DEST_RNS  = 7;
    localparam int CTRL_OUTP      = 8;
    localparam int CTRL_INP       = 9;

    localparam int BR_CMP_LSB  = 0;
    localparam int BR_CMP_MSB  = 2;
    localparam int BR_CARRY    = 3;
    localparam int BR_CMP_TRUE = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        IO_WAIT  = 2'd2
    } state_t;

    // Bits needed to hold values 0..maxval (at least one bit).
    function automatic int ctr_width(input int maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/pl_memwb_wait_ctr.sv
// Loadable down-counter with zero flag.
//   clk, reset : clock, async active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement, saturating at 0
//   zero       : count == 0
module pl_memwb_wait_ctr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pl_memwb_hs.sv
// MEM/WB pipeline stage with valid/ready handshake towards EX.
// ALU ops complete in one cycle; loads wait DMEM_LAT cycles in MEM_WAIT;
// IO reads wait for io_read_ack in IO_WAIT, aborting after IO_TIMEOUT cycles.
// The ack window is cycle T (accept) plus IO_TIMEOUT wait cycles; an abort
// shows io_timeout together with wb_valid (reg_wr_en=0, wr_data=0) the cycle after.
// Ports:
//   clk, reset                       clock, async active-high reset
//   ex_valid/ex_ready                handshake from EX (ready == IDLE)
//   ex_ctrl, ex_dest, operation_result, branch_conds_ex   EX register contents
//   dmem_dout, dmem_rd_en, mem_wr_en data-memory interface
//   io_read_*, io_write_*, io_timeout  IO port interface
//   wb_valid, reg_wr_en, wb_dest, wr_data, branch_conds_memwb  registered write-back
//   invalidate_instr                 combinational flush request
// Optional: define PL_MEMWB_FWD_EN to add fwd_valid/fwd_dest/fwd_data bypass outputs.
module pl_memwb_hs
    import pl_memwb_hs_pkg::*;
#(
    parameter int NUM_DOMAINS  = 1,
    parameter int DATA_WID     = 8,
    parameter int REG_ADDR_WID = 3,
    parameter int DMEM_LAT     = 1,
    parameter int IO_TIMEOUT   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ex_valid,
    output logic                            ex_ready,
    input  logic [CTRL_W-1:0]               ex_ctrl,
    input  logic [REG_ADDR_WID-1:0]         ex_dest,
    input  logic [NUM_DOMAINS*DATA_WID-1:0] operation_result,
    input  logic [4:0]                      branch_conds_ex,
    input  logic [DATA_WID-1:0]             dmem_dout,
    input  logic [DATA_WID-1:0]             io_read_data,
    input  logic                            io_read_ack,
    output logic                            mem_wr_en,
    output logic                            dmem_rd_en,
    output logic                            invalidate_instr,
    output logic                            io_read_strobe,
    output logic                            io_write_strobe,
    output logic [DATA_WID-1:0]             io_write_data,
    output logic                            io_timeout,
    output logic                            wb_valid,
    output logic                            reg_wr_en,
    output logic [REG_ADDR_WID-1:0]         wb_dest,
    output logic [NUM_DOMAINS*DATA_WID-1:0] wr_data,
    output logic [3:0]                      branch_conds_memwb
`ifdef PL_MEMWB_FWD_EN
    ,
    output logic                            fwd_valid,
    output logic [REG_ADDR_WID-1:0]         fwd_dest,
    output logic [NUM_DOMAINS*DATA_WID-1:0] fwd_data
`endif
);

    localparam int RES_W = NUM_DOMAINS * DATA_WID;
    localparam int MEM_W = ctr_width(DMEM_LAT);
    localparam int IO_W  = ctr_width(IO_TIMEOUT);
    localparam logic [MEM_W-1:0] MEM_LOAD = MEM_W'((DMEM_LAT > 0) ? DMEM_LAT - 1 : 0);
    localparam logic [IO_W-1:0]  IO_LOAD  = IO_W'(IO_TIMEOUT - 1);

    state_t                  state;
    logic                    take;
    logic                    is_inp;
    logic                    is_load;
    logic                    mem_zero;
    logic                    io_zero;
    logic                    pend_reg_wr;
    logic [REG_ADDR_WID-1:0] pend_dest;
    logic                    unused_dest_rns;

    assign unused_dest_rns  = ex_ctrl[CTRL_DEST_RNS];

    assign ex_ready         = (state == IDLE);
    assign invalidate_instr = (ex_ctrl[CTRL_INV_EX] | ex_ctrl[CTRL_INV_FETCH] |
                               ex_ctrl[CTRL_INV_DEC]) & ex_valid;
    assign take             = ex_valid & ex_ready & ~invalidate_instr;
    assign is_inp           = take & ex_ctrl[CTRL_INP];
    // inp outranks load: no memory read is issued for an instruction with both
    assign is_load          = take & ex_ctrl[CTRL_LOAD] & ~ex_ctrl[CTRL_INP];

    assign mem_wr_en        = take & ex_ctrl[CTRL_STORE];
    assign dmem_rd_en       = is_load;
    assign io_read_strobe   = is_inp | (state == IO_WAIT);

    pl_memwb_wait_ctr #(.W(MEM_W)) u_mem_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (is_load),
        .load_val (MEM_LOAD),
        .dec      (state == MEM_WAIT),
        .zero     (mem_zero)
    );

    pl_memwb_wait_ctr #(.W(IO_W)) u_io_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (is_inp & ~io_read_ack),
        .load_val (IO_LOAD),
        .dec      (state == IO_WAIT),
        .zero     (io_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            wb_valid           <= 1'b0;
            reg_wr_en          <= 1'b0;
            wb_dest            <= '0;
            wr_data            <= '0;
            branch_conds_memwb <= '0;
            io_write_strobe    <= 1'b0;
            io_write_data      <= '0;
            io_timeout         <= 1'b0;
            pend_reg_wr        <= 1'b0;
            pend_dest          <= '0;
        end else begin
            // pulse-type outputs fall back to 0 unless something completes
            wb_valid           <= 1'b0;
            reg_wr_en          <= 1'b0;
            io_write_strobe    <= 1'b0;
            io_timeout         <= 1'b0;
            branch_conds_memwb <= '0;

            if (take) begin
                branch_conds_memwb[BR_CARRY] <= ex_ctrl[CTRL_SAVE_COUT] & branch_conds_ex[BR_CARRY];
                branch_conds_memwb[BR_CMP_MSB:BR_CMP_LSB] <= branch_conds_ex[BR_CMP_TRUE] ?
                    branch_conds_ex[BR_CMP_MSB:BR_CMP_LSB] : 3'b000;
                pend_reg_wr <= ex_ctrl[CTRL_REG_WR];
                pend_dest   <= ex_dest;
                if (ex_ctrl[CTRL_OUTP]) begin
                    io_write_strobe <= 1'b1;
                    io_write_data   <= operation_result[DATA_WID-1:0];
                end
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        if (ex_ctrl[CTRL_INP] && !io_read_ack) begin
                            state <= IO_WAIT;
                        end else if (is_load && DMEM_LAT > 0) begin
                            state <= MEM_WAIT;
                        end else begin
                            wb_valid  <= 1'b1;
                            reg_wr_en <= ex_ctrl[CTRL_REG_WR];
                            wb_dest   <= ex_dest;
                            if (ex_ctrl[CTRL_INP])
                                wr_data <= RES_W'(io_read_data);
                            else if (ex_ctrl[CTRL_LOAD])
                                wr_data <= RES_W'(dmem_dout);
                            else
                                wr_data <= operation_result;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_zero) begin
                        state     <= IDLE;
                        wb_valid  <= 1'b1;
                        reg_wr_en <= pend_reg_wr;
                        wb_dest   <= pend_dest;
                        wr_data   <= RES_W'(dmem_dout);
                    end
                end
                IO_WAIT: begin
                    // an ack on the last allowed cycle still wins over the abort
                    if (io_read_ack) begin
                        state     <= IDLE;
                        wb_valid  <= 1'b1;
                        reg_wr_en <= pend_reg_wr;
                        wb_dest   <= pend_dest;
                        wr_data   <= RES_W'(io_read_data);
                    end else if (io_zero) begin
                        state      <= IDLE;
                        wb_valid   <= 1'b1;
                        wb_dest    <= pend_dest;
                        wr_data    <= '0;
                        io_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PL_MEMWB_FWD_EN
    assign fwd_valid = wb_valid & reg_wr_en;
    assign fwd_dest  = wb_dest;
    assign fwd_data  = wr_data;
`endif

endmodule

// File: tb/tb_pl_memwb_hs.sv
module tb_pl_memwb_hs;

    localparam logic [9:0] C_STORE = 10'h001;
    localparam logic [9:0] C_REGWR = 10'h002;
    localparam logic [9:0] C_COUT  = 10'h004;
    localparam logic [9:0] C_LOAD  = 10'h010;
    localparam logic [9:0] C_INVF  = 10'h020;
    localparam logic [9:0] C_OUTP  = 10'h100;
    localparam logic [9:0] C_INP   = 10'h200;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [9:0]  ex_ctrl;
    logic [2:0]  ex_dest;
    logic [15:0] operation_result;
    logic [4:0]  branch_conds_ex;
    logic [7:0]  dmem_dout;
    logic [7:0]  io_read_data;
    logic        io_read_ack;
    logic        mem_wr_en;
    logic        dmem_rd_en;
    logic        invalidate_instr;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [7:0]  io_write_data;
    logic        io_timeout;
    logic        wb_valid;
    logic        reg_wr_en;
    logic [2:0]  wb_dest;
    logic [15:0] wr_data;
    logic [3:0]  branch_conds_memwb;

    typedef struct {
        logic        reg_wr;
        logic [2:0]  dest;
        logic [15:0] data;
        logic        to;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pl_memwb_hs #(
        .NUM_DOMAINS(2), .DATA_WID(8), .REG_ADDR_WID(3), .DMEM_LAT(2), .IO_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_ctrl(ex_ctrl), .ex_dest(ex_dest), .operation_result(operation_result),
        .branch_conds_ex(branch_conds_ex), .dmem_dout(dmem_dout),
        .io_read_data(io_read_data), .io_read_ack(io_read_ack),
        .mem_wr_en(mem_wr_en), .dmem_rd_en(dmem_rd_en),
        .invalidate_instr(invalidate_instr), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_write_data(io_write_data),
        .io_timeout(io_timeout), .wb_valid(wb_valid), .reg_wr_en(reg_wr_en),
        .wb_dest(wb_dest), .wr_data(wr_data), .branch_conds_memwb(branch_conds_memwb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rw, input logic [2:0] d, input logic [15:0] v, input logic t);
        exp_t e;
        e.reg_wr = rw; e.dest = d; e.data = v; e.to = t;
        sb.push_back(e);
    endtask

    // write-back monitor: every wb_valid must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected dest=%h data=%h at %0t", wb_dest, wr_data, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_reg_wr_en", reg_wr_en, mon_e.reg_wr);
                if (!mon_e.to) chk("wb_dest", wb_dest, mon_e.dest);
                chk("wb_wr_data", wr_data, mon_e.data);
                chk("wb_io_timeout", io_timeout, mon_e.to);
            end
        end
        if (!reset && io_timeout && !wb_valid) begin
            checks++;
            failures++;
            $display("FAIL timeout_without_wb at %0t", $time);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ex_valid = 0; ex_ctrl = 0; ex_dest = 0; operation_result = 0;
        branch_conds_ex = 0; dmem_dout = 0; io_read_data = 0; io_read_ack = 0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_io_rd_strobe", io_read_strobe, 0);
        chk("rst_branch", branch_conds_memwb, 0);
        chk("rst_io_wr_strobe", io_write_strobe, 0);
        cyc(); reset = 1'b0;

        // ALU op, carry saved, compare not true
        cyc(); ex_valid = 1; ex_ctrl = C_REGWR | C_COUT; ex_dest = 3;
        operation_result = 16'h115A; branch_conds_ex = 5'b01011;
        push(1, 3, 16'h115A, 0);
        @(negedge clk);
        chk("alu_ready", ex_ready, 1);
        chk("alu_mem_wr", mem_wr_en, 0);
        chk("alu_rd_en", dmem_rd_en, 0);
        chk("alu_inval", invalidate_instr, 0);
        cyc(); ex_valid = 0; operation_result = 16'hFFFF; ex_dest = 7; branch_conds_ex = 0;
        @(negedge clk);
        chk("alu_branch", branch_conds_memwb, 4'b1000);

        // store + outp, compare true 110, carry not saved
        cyc(); ex_valid = 1; ex_ctrl = C_STORE | C_OUTP; ex_dest = 5;
        operation_result = 16'h0042; branch_conds_ex = 5'b10110;
        push(0, 5, 16'h0042, 0);
        @(negedge clk);
        chk("st_mem_wr", mem_wr_en, 1);
        cyc(); ex_valid = 0; ex_ctrl = 0; operation_result = 0; branch_conds_ex = 0;
        @(negedge clk);
        chk("outp_strobe", io_write_strobe, 1);
        chk("outp_data", io_write_data, 8'h42);
        chk("st_branch", branch_conds_memwb, 4'b0110);
        chk("st_mem_wr_off", mem_wr_en, 0);
        cyc();
        @(negedge clk);
        chk("outp_strobe_off", io_write_strobe, 0);
        chk("branch_cleared", branch_conds_memwb, 0);

        // invalidated store: no side effects
        cyc(); ex_valid = 1; ex_ctrl = C_STORE | C_INVF | C_REGWR | C_OUTP; ex_dest = 1;
        operation_result = 16'h00AA; branch_conds_ex = 5'b10101;
        @(negedge clk);
        chk("inv_flag", invalidate_instr, 1);
        chk("inv_mem_wr", mem_wr_en, 0);
        cyc(); ex_valid = 0; ex_ctrl = 0;
        @(negedge clk);
        chk("inv_branch", branch_conds_memwb, 0);
        chk("inv_wb_valid", wb_valid, 0);
        chk("inv_io_wr", io_write_strobe, 0);

        // valid compare 101, carry present but not saved
        cyc(); ex_valid = 1; ex_ctrl = 0; ex_dest = 2; operation_result = 16'h1234;
        branch_conds_ex = 5'b11101;
        push(0, 2, 16'h1234, 0);
        cyc(); ex_valid = 0; branch_conds_ex = 0;
        @(negedge clk);
        chk("cmp_branch", branch_conds_memwb, 4'b0101);

        // load, DMEM_LAT=2; EX keeps offering a store while stalled
        cyc(); ex_valid = 1; ex_ctrl = C_LOAD | C_REGWR; ex_dest = 6;
        operation_result = 16'h0010; dmem_dout = 8'h11;
        push(1, 6, 16'h00C3, 0);
        @(negedge clk);
        chk("ld_rd_en", dmem_rd_en, 1);
        chk("ld_ready_T", ex_ready, 1);
        cyc(); ex_ctrl = C_STORE | C_REGWR; ex_dest = 7;
        @(negedge clk);
        chk("ld_ready_T1", ex_ready, 0);
        chk("ld_ignored_store", mem_wr_en, 0);
        chk("ld_rd_en_T1", dmem_rd_en, 0);
        cyc(); ex_valid = 0; ex_ctrl = 0; dmem_dout = 8'hC3;
        @(negedge clk);
        chk("ld_ready_T2", ex_ready, 0);
        cyc(); dmem_dout = 8'h55;
        @(negedge clk);
        chk("ld_ready_T3", ex_ready, 1);

        // load + inp: inp wins, ack in T
        cyc(); ex_valid = 1; ex_ctrl = C_LOAD | C_INP | C_REGWR; ex_dest = 2;
        io_read_ack = 1; io_read_data = 8'h3C;
        push(1, 2, 16'h003C, 0);
        @(negedge clk);
        chk("li_rd_en", dmem_rd_en, 0);
        chk("li_strobe", io_read_strobe, 1);
        cyc(); ex_valid = 0; ex_ctrl = 0; io_read_ack = 0; io_read_data = 0;
        @(negedge clk);
        chk("li_ready", ex_ready, 1);
        chk("li_strobe_off", io_read_strobe, 0);

        // inp, ack on T+4 (last cycle of the window)
        cyc(); ex_valid = 1; ex_ctrl = C_INP | C_REGWR; ex_dest = 4;
        push(1, 4, 16'h007E, 0);
        @(negedge clk);
        chk("io_strobe_T", io_read_strobe, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc(); ex_valid = 0; ex_ctrl = 0;
            @(negedge clk);
            chk("io_strobe_wait", io_read_strobe, 1);
            chk("io_ready_wait", ex_ready, 0);
        end
        cyc(); io_read_ack = 1; io_read_data = 8'h7E;
        @(negedge clk);
        chk("io_strobe_ack", io_read_strobe, 1);
        cyc(); io_read_ack = 0; io_read_data = 0;
        @(negedge clk);
        chk("io_strobe_done", io_read_strobe, 0);
        chk("io_ready_done", ex_ready, 1);

        // inp, never acked
        cyc(); ex_valid = 1; ex_ctrl = C_INP | C_REGWR; ex_dest = 5;
        push(0, 5, 16'h0000, 1);
        @(negedge clk);
        chk("to_strobe_T", io_read_strobe, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc(); ex_valid = 0; ex_ctrl = 0;
            @(negedge clk);
            chk("to_strobe_wait", io_read_strobe, 1);
            chk("to_no_pulse_yet", io_timeout, 0);
        end
        cyc();
        @(negedge clk);
        chk("to_pulse", io_timeout, 1);
        chk("to_strobe_off", io_read_strobe, 0);
        chk("to_ready", ex_ready, 1);
        cyc();
        @(negedge clk);
        chk("to_pulse_off", io_timeout, 0);

        // reset in the middle of MEM_WAIT
        cyc(); ex_valid = 1; ex_ctrl = C_LOAD | C_REGWR; ex_dest = 3;
        branch_conds_ex = 5'b10111;
        @(negedge clk);
        chk("rl_rd_en", dmem_rd_en, 1);
        cyc(); ex_valid = 0; ex_ctrl = 0; branch_conds_ex = 0;
        @(negedge clk);
        chk("rl_stalled", ex_ready, 0);
        chk("rl_branch", branch_conds_memwb, 4'b0111);
        #2 reset = 1'b1;
        #1;
        chk("rl_branch_rst", branch_conds_memwb, 0);
        chk("rl_ready_rst", ex_ready, 1);
        chk("rl_wb_valid_rst", wb_valid, 0);
        chk("rl_reg_wr_rst", reg_wr_en, 0);
        chk("rl_wr_data_rst", wr_data, 0);
        chk("rl_strobe_rst", io_read_strobe, 0);
        cyc(); cyc(); reset = 1'b0;
        repeat (3) begin
            cyc();
            @(negedge clk);
            chk("rl_ready_after", ex_ready, 1);
        end

        // normal operation after reset
        cyc(); ex_valid = 1; ex_ctrl = C_REGWR; ex_dest = 7; operation_result = 16'hBEEF;
        push(1, 7, 16'hBEEF, 0);
        cyc(); ex_valid = 0; ex_ctrl = 0;
        repeat (3) cyc();
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
